move_sequencer: RTL

//   Owns the active piece state (block, blockX, blockY) and the settled 20x20 field.

---
 rtl/move_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/move_sequencer.sv
// Active-piece sequencer: serialises moves and gravity into one predictor op at a time,
// commits accepted results, locks failed drops into the settled field and respawns.
module move_sequencer #(
    parameter logic [4:0] SPAWN_X = 5'd8,
    parameter logic [4:0] SPAWN_Y = 5'd0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req_left,
    input  logic         i_req_right,
    input  logic         i_req_rot,
    input  logic         i_grav_tick,
    input  logic [0:15]  i_next_block,
    input  logic         i_pred_ok,
    input  logic [0:15]  i_pred_block,
    input  logic [0:399] i_merge_field,
    output logic [2:0]   o_pred_op,
    output logic [4:0]   o_pred_x,
    output logic [4:0]   o_pred_y,
    output logic [0:15]  o_block,
    output logic [0:399] o_field,
    output logic         o_lock_pulse,
    output logic         o_busy,
    output logic         o_game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_LOCK,
        S_SPAWN,
        S_SCHK,
        S_OVER
    } state_t;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_LEFT  = 3'd1;
    localparam logic [2:0] OP_RIGHT = 3'd2;
    localparam logic [2:0] OP_ROT   = 3'd3;
    localparam logic [2:0] OP_DOWN  = 3'd4;
    localparam logic [2:0] OP_SPAWN = 3'd5;

    state_t       r_state;
    state_t       w_next_state;
    logic [2:0]   r_pred_op;
    logic [2:0]   w_pred_op;
    logic [4:0]   r_x;
    logic [4:0]   w_x;
    logic [4:0]   r_y;
    logic [4:0]   w_y;
    logic [0:15]  r_block;
    logic [0:15]  w_block;
    logic [0:399] r_field;
    logic [0:399] w_field;
    logic [3:0]   r_pending;
    logic [3:0]   w_pending;
    logic [3:0]   w_issue;
    logic [3:0]   w_req;
    logic         r_lock_pulse;
    logic         r_busy;
    logic         r_game_over;

    // Pending bit order doubles as issue priority: down, rotate, left, right.
    assign w_req = {i_grav_tick, i_req_rot, i_req_left, i_req_right};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_SPAWN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pred_op    = OP_NONE;
        w_x          = r_x;
        w_y          = r_y;
        w_block      = r_block;
        w_field      = r_field;
        w_issue      = 4'b0000;
        case (r_state)
            S_IDLE: begin
                if (r_pending[3]) begin
                    w_pred_op = OP_DOWN;
                    w_issue   = 4'b1000;
                end else if (r_pending[2]) begin
                    w_pred_op = OP_ROT;
                    w_issue   = 4'b0100;
                end else if (r_pending[1]) begin
                    w_pred_op = OP_LEFT;
                    w_issue   = 4'b0010;
                end else if (r_pending[0]) begin
                    w_pred_op = OP_RIGHT;
                    w_issue   = 4'b0001;
                end
                if (r_pending != 4'b0000) begin
                    w_next_state = S_EVAL;
                end
            end
            S_EVAL: begin
                w_next_state = S_IDLE;
                if (i_pred_ok) begin
                    case (r_pred_op)
                        OP_LEFT:  w_x = r_x - 5'd1;
                        OP_RIGHT: w_x = r_x + 5'd1;
                        OP_ROT:   w_block = i_pred_block;
                        OP_DOWN:  w_y = r_y + 5'd1;
                        default:  w_x = r_x;
                    endcase
                end else if (r_pred_op == OP_DOWN) begin
                    w_next_state = S_LOCK;
                end
            end
            S_LOCK: begin
                w_field      = i_merge_field;
                w_next_state = S_SPAWN;
            end
            S_SPAWN: begin
                w_block      = i_next_block;
                w_x          = SPAWN_X;
                w_y          = SPAWN_Y;
                w_pred_op    = OP_SPAWN;
                w_next_state = S_SCHK;
            end
            S_SCHK: begin
                w_next_state = i_pred_ok ? S_IDLE : S_OVER;
            end
            default: begin
                w_next_state = S_OVER;
            end
        endcase

        // Moves queued before a lock belong to the old piece, so LOCK discards them.
        if (r_state == S_LOCK || r_state == S_OVER) begin
            w_pending = 4'b0000;
        end else begin
            w_pending = (r_pending & ~w_issue) | w_req;
        end
    end

    // Status flags are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pred_op    <= OP_NONE;
            r_x          <= SPAWN_X;
            r_y          <= SPAWN_Y;
            r_block      <= '0;
            r_field      <= '0;
            r_pending    <= 4'b0000;
            r_lock_pulse <= 1'b0;
            r_busy       <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_pred_op    <= w_pred_op;
            r_x          <= w_x;
            r_y          <= w_y;
            r_block      <= w_block;
            r_field      <= w_field;
            r_pending    <= w_pending;
            r_lock_pulse <= (w_next_state == S_LOCK);
            r_busy       <= (w_next_state != S_IDLE) && (w_next_state != S_OVER);
            r_game_over  <= (w_next_state == S_OVER);
        end
    end

    assign o_pred_op    = r_pred_op;
    assign o_pred_x     = r_x;
    assign o_pred_y     = r_y;
    assign o_block      = r_block;
    assign o_field      = r_field;
    assign o_lock_pulse = r_lock_pulse;
    assign o_busy       = r_busy;
    assign o_game_over  = r_game_over;

endmodule
